// File: rtl/fmeter_gen.sv
// fmeter_gen: counts input edges over a programmable gate window in a BCD
// counter, snapshots each window and sends it as an ASCII frame over 8N1 UART.
//
// Ports:
//   CLK100MHz  system clock
//   RST        synchronous reset, active-high
//   FREQIN     asynchronous signal to measure
//   TXD        UART serial out, idles high
//   LED1       toggles at every gate end
//   LED2       mirror of TXD
//   OVF        overflow flag of the most recently snapshotted window
//   BUSY       high while a frame is being sent
//   DROP       one-cycle pulse when an unsent snapshot is overwritten
module fmeter_gen #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned BAUD_DIV    = 1736,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned LZ_BLANK    = 0
) (
    input  logic CLK100MHz,
    input  logic RST,
    input  logic FREQIN,
    output logic TXD,
    output logic LED1,
    output logic LED2,
    output logic OVF,
    output logic BUSY,
    output logic DROP
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam int unsigned BYTE_W = $clog2(DIGITS + 3);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    logic                    sync0, sync1, hist;
    logic                    rise, fall, edge_det;
    logic [DIGITS-1:0][3:0]  cnt, cnt_inc, cnt_next;
    logic                    carry_out, ovf_flag, ovf_set;
    logic [GATE_W-1:0]       gate_cnt;
    logic                    gate_end;
    logic [DIGITS-1:0][3:0]  pend_digits, tx_digits;
    logic                    pend_ovf, pend_valid, tx_ovf;
    logic [DIGITS-1:0]       blank;
    logic [7:0]              tx_byte_c;

    tx_state_e               state, state_n;
    logic [BAUD_W-1:0]       baud_cnt, baud_n;
    logic [2:0]              bit_idx, bit_n;
    logic [BYTE_W-1:0]       byte_idx, byte_n;
    logic                    txd_n, busy_n, start_c, baud_last;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync0 <= FREQIN;
            sync1 <= sync0;
            hist  <= sync1;
        end
    end

    assign rise = sync1 & ~hist;
    assign fall = ~sync1 & hist;

    // Edge selection
    always_comb begin
        case (EDGE_MODE)
            1:       edge_det = rise;
            2:       edge_det = rise | fall;
            default: edge_det = fall;
        endcase
    end

    // BCD ripple increment; carry out of the top digit means saturation
    always_comb begin
        logic carry;
        carry   = 1'b1;
        cnt_inc = cnt;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (cnt[i] == 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        carry_out = carry;
    end

    assign cnt_next = (edge_det && !carry_out) ? cnt_inc : cnt;
    assign ovf_set  = edge_det & carry_out;
    assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

    // Gate window, BCD counter and window overflow flag
    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            gate_cnt <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            LED1     <= 1'b0;
            OVF      <= 1'b0;
        end else if (gate_end) begin
            gate_cnt <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            LED1     <= ~LED1;
            OVF      <= ovf_flag | ovf_set;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            cnt      <= cnt_next;
            ovf_flag <= ovf_flag | ovf_set;
        end
    end

    // One-entry pending buffer; a frame start frees it in the same cycle a
    // new snapshot may land, so that case is not a drop
    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            pend_valid  <= 1'b0;
            pend_digits <= '0;
            pend_ovf    <= 1'b0;
            DROP        <= 1'b0;
        end else begin
            DROP <= gate_end & pend_valid & ~start_c;
            if (gate_end) begin
                pend_digits <= cnt_next;
                pend_ovf    <= ovf_flag | ovf_set;
                pend_valid  <= 1'b1;
            end else if (start_c) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Transmit copy, frozen for the whole frame
    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            tx_digits <= '0;
            tx_ovf    <= 1'b0;
        end else if (start_c) begin
            tx_digits <= pend_digits;
            tx_ovf    <= pend_ovf;
        end
    end

    // Leading-zero mask, scanned from the most significant digit; digit 0 never blanks
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (tx_digits[i] != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            blank[i] = lead && (LZ_BLANK != 0);
        end
    end

    // Frame byte for the current byte index
    always_comb begin
        tx_byte_c = 8'h0A;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (byte_idx == BYTE_W'(int'(DIGITS) - 1 - i)) begin
                tx_byte_c = blank[i] ? 8'h20 : {4'h3, tx_digits[i]};
            end
        end
        if (byte_idx == BYTE_W'(DIGITS)) begin
            tx_byte_c = tx_ovf ? 8'h3E : 8'h3D;
        end else if (byte_idx == BYTE_W'(DIGITS + 1)) begin
            tx_byte_c = 8'h0D;
        end
    end

    // UART TX state register
    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            TXD      <= 1'b1;
            LED2     <= 1'b1;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            TXD      <= txd_n;
            LED2     <= txd_n;
            BUSY     <= busy_n;
        end
    end

    // UART TX next state and outputs; bytes run back to back until LF
    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_idx;
        byte_n    = byte_idx;
        txd_n     = TXD;
        busy_n    = BUSY;
        start_c   = 1'b0;
        baud_last = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
        case (state)
            IDLE: begin
                txd_n  = 1'b1;
                busy_n = 1'b0;
                if (pend_valid) begin
                    start_c = 1'b1;
                    state_n = START;
                    baud_n  = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    txd_n   = tx_byte_c[0];
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        txd_n = tx_byte_c[bit_n];
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (byte_idx == BYTE_W'(DIGITS + 2)) begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        byte_n  = byte_idx + BYTE_W'(1);
                        state_n = START;
                        txd_n   = 1'b0;
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fmeter_gen.sv
// tb_fmeter_gen: randomized FREQIN patterns against a cycle-indexed behavioural
// model of windows, pending buffer and serial frames; includes a mid-frame reset.
module tb_fmeter_gen;

    localparam int G    = 176;
    localparam int D    = 2;
    localparam int B    = 7;
    localparam int MODE = 2;
    localparam int LZ   = 1;
    localparam int L    = (D + 3) * 10 * B;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    logic rst, freqin;
    logic txd, led1, led2, ovf, busy, drop;

    always #5 clk = ~clk;

    fmeter_gen #(
        .GATE_CYCLES(G),
        .DIGITS     (D),
        .BAUD_DIV   (B),
        .EDGE_MODE  (MODE),
        .LZ_BLANK   (LZ)
    ) dut (
        .CLK100MHz(clk),
        .RST      (rst),
        .FREQIN   (freqin),
        .TXD      (txd),
        .LED1     (led1),
        .LED2     (led2),
        .OVF      (ovf),
        .BUSY     (busy),
        .DROP     (drop)
    );

    int n_cmp, n_err;
    int n;
    int p0;
    int cnt [256];
    bit win_ovf [256];
    int idle_at;
    bit mb_valid;
    int mb_val;
    bit mb_ovf;
    bit fact;
    int fs, fval;
    bit fovf;
    int drop_at;
    bit prev_v;
    bit cur;
    int style, half, ph;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] frame_byte(input int val, input bit o_flag, input int idx);
        int sc, dg;
        if (idx < D) begin
            sc = pow10(D - 1 - idx);
            dg = (val / sc) % 10;
            if (LZ != 0 && idx < D - 1 && (val / sc) == 0) return 8'h20;
            return 8'(8'h30 + dg);
        end
        if (idx == D) return o_flag ? 8'h3E : 8'h3D;
        if (idx == D + 1) return 8'h0D;
        return 8'h0A;
    endfunction

    // Line level at offset o into a frame: start bit, 8 data bits LSB first, stop bit
    function automatic bit frame_bit(input int o, input int val, input bit o_flag);
        int bi, by, pos;
        logic [7:0] b;
        bi  = o / B;
        by  = bi / 10;
        pos = bi % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = frame_byte(val, o_flag, by);
        return b[pos-1];
    endfunction

    task automatic model_reset(input int p);
        p0 = p;
        for (int i = 0; i < 256; i++) begin
            cnt[i]     = 0;
            win_ovf[i] = 1'b0;
        end
        idle_at  = p;
        mb_valid = 1'b0;
        mb_val   = 0;
        mb_ovf   = 1'b0;
        fact     = 1'b0;
        fs       = 0;
        fval     = 0;
        fovf     = 1'b0;
        drop_at  = -1;
        prev_v   = 1'b0;
    endtask

    // Pin value for cycle n; a new random pattern style is drawn each window
    task automatic next_stim(output bit v);
        if (((n - p0) % G) == 0) begin
            style = int'($urandom_range(0, 4));
            half  = int'($urandom_range(1, 6));
            ph    = 0;
        end
        ph++;
        case (style)
            1: if (ph >= half) begin cur = ~cur; ph = 0; end
            2: if ($urandom_range(0, 1) == 1) cur = ~cur;
            3: if ($urandom_range(0, 39) == 0) cur = ~cur;
            4: cur = ~cur;
            default: ;
        endcase
        v = cur;
    endtask

    // Advance the model by one cycle given the pin value driven in it
    task automatic model_update(input bit v);
        bit counted, was_full, start, gend;
        int k;
        counted = (MODE == 0 && prev_v && !v) || (MODE == 1 && !prev_v && v) ||
                  (MODE == 2 && prev_v != v);
        // a pin change is seen by the counter two cycles later
        if (counted) cnt[(n + 2 - p0) / G]++;
        prev_v   = v;
        was_full = mb_valid;
        start    = (n >= idle_at) && mb_valid;
        gend     = ((n - p0) % G) == G - 1;
        if (start) begin
            fact     = 1'b1;
            fs       = n + 1;
            fval     = mb_val;
            fovf     = mb_ovf;
            idle_at  = n + L + 1;
            mb_valid = 1'b0;
        end
        if (gend) begin
            k          = (n - p0) / G;
            win_ovf[k] = cnt[k] > MAXV;
            if (was_full && !start) drop_at = n + 1;
            mb_val   = (cnt[k] > MAXV) ? MAXV : cnt[k];
            mb_ovf   = win_ovf[k];
            mb_valid = 1'b1;
        end
    endtask

    // One clock: compare outputs of this cycle, then drive the next inputs
    task automatic step(input bit arm_rst, output bit did_rst);
        int completed, o, bi, pos, ebit, eovf;
        bit in_frame, v, fire;
        @(posedge clk);
        #1;
        completed = (n - p0) / G;
        in_frame  = fact && n >= fs && n < fs + L;
        o         = n - fs;
        ebit      = in_frame ? int'(frame_bit(o, fval, fovf)) : 1;
        if (completed == 0) eovf = 0;
        else eovf = int'(win_ovf[completed - 1]);
        check("led1", int'(led1), completed % 2);
        check("ovf",  int'(ovf),  eovf);
        check("busy", int'(busy), int'(in_frame));
        check("drop", int'(drop), int'(n == drop_at));
        check("txd",  int'(txd),  ebit);
        check("led2", int'(led2), ebit);
        fire = 1'b0;
        if (arm_rst && in_frame) begin
            bi   = o / B;
            pos  = bi % 10;
            fire = pos >= 1 && pos <= 8 && (o % B) == B / 2 && ebit == 0;
        end
        rst = fire;
        next_stim(v);
        freqin = v;
        if (fire) model_reset(n + 1);
        else model_update(v);
        did_rst = fire;
        n++;
    endtask

    initial begin
        bit dr, hit;
        n_cmp  = 0;
        n_err  = 0;
        n      = 0;
        rst    = 1'b1;
        freqin = 1'b0;
        cur    = 1'b0;
        style  = 0;
        half   = 1;
        ph     = 0;
        model_reset(0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5000; i++) step(1'b0, dr);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step(1'b1, dr);
            hit = dr;
        end
        check("rst_in_data_bit", int'(hit), 1);
        for (int i = 0; i < 4500; i++) step(1'b0, dr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fmeter_gen.md
Name: fmeter_gen

Overview:
- Parametrised successor to the single-channel frequency meter.
- Counts edges on FREQIN over a programmable gate window in a DIGITS-wide BCD counter, snapshots the result at each gate end, and transmits it as a fixed-length ASCII frame over an 8N1 UART.
- Adds selectable edge mode, saturation/overflow flagging, optional leading-zero blanking, a proper UART TX state machine, and a single pending-frame buffer.
- Sits directly between the board input pin and the host serial link.

Parameters:
GATE_CYCLES, 100000000, clock cycles per measurement window (1 s at 100 MHz); legal range 2 and up
DIGITS, 8, number of BCD digits in counter and frame; legal range 1..16
BAUD_DIV, 1736, clock cycles per UART bit (57600 bps at 100 MHz); legal range 2 and up
EDGE_MODE, 0, 0 = falling edges, 1 = rising edges, 2 = both edges
LZ_BLANK, 0, 1 = transmit leading zero digits as ASCII space; the least significant digit is always numeric

Ports:
CLK100MHz  input  1  system clock
RST  input  1  synchronous reset, active-high
FREQIN  input  1  asynchronous signal to measure
TXD  output  1  UART serial out, idles high
LED1  output  1  toggles at every gate end
LED2  output  1  mirror of TXD
OVF  output  1  registered; overflow flag of the most recently snapshotted window
BUSY  output  1  high while the UART is sending a frame
DROP  output  1  one-cycle pulse when a pending, unsent snapshot is overwritten

Behaviour:
- Reset: all state is cleared synchronously while RST is high.
  - TXD=1, LED1=0, OVF=0, BUSY=0, DROP=0.
  - Gate counter = 0, BCD digits = 0, overflow flag = 0, pending buffer empty, TX FSM in IDLE.
- Reset mid-frame: the frame is aborted. TXD reads 1 in the cycle after RST is sampled high.
- Input path:
  - FREQIN passes through 2 synchroniser flops, then 1 history flop.
  - An edge is detected by comparing the synchronised value with the history flop, per EDGE_MODE.
  - Latency from pin to count is 3 clocks.
- BCD counter:
  - Each edge increments digit 0. A digit wraps 9 to 0 and carries into the next digit.
  - All digits at 9 plus an edge: the counter saturates (holds all 9s) and the window overflow flag is set.
  - Only values 0..9 ever appear in a digit.
- Gate:
  - The gate counter counts 0..GATE_CYCLES-1.
  - On the terminal cycle:
    - The snapshot takes the counter's next value, so an edge detected in the terminal cycle belongs to the closing window.
    - The snapshot also takes the overflow flag.
    - Counter and flag clear to 0.
    - LED1 toggles.
    - OVF updates.
- Pending buffer:
  - The snapshot is written to a one-entry buffer.
  - If the buffer already holds an unsent snapshot, it is overwritten (latest value wins) and DROP pulses in the same cycle.
- Frame format: DIGITS+3 bytes.
  - Digit bytes, most significant first, each 0x30+digit. With LZ_BLANK=1, leading zeros are sent as 0x20.
  - A flag byte: '=' (0x3D) normally, '>' (0x3E) if the window overflowed.
  - CR (0x0D), then LF (0x0A).
- Frame sequencer:
  - In IDLE with the pending buffer full, it moves the buffer into the transmit register, empties the buffer, asserts BUSY, and starts at byte index 0.
  - Once started, a frame always completes with the values captured at start.
  - BUSY deasserts in the cycle after the last stop bit ends.
- UART TX FSM:
  - States: IDLE, START, DATA, STOP.
  - START: TXD=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each.
  - STOP: TXD=1 for BAUD_DIV cycles.
  - The next byte follows immediately, with no extra idle, until the LF byte is done.
  - The baud counter restarts at 0 at the beginning of each frame.
- Simultaneous events:
  - Gate end in the same cycle as frame start: the sequencer takes the old buffer contents, and the new snapshot goes into the just-emptied buffer with no DROP.
  - Gate end in the same cycle as an edge: as defined above under Gate.
- Widths:
  - Gate counter: clog2(GATE_CYCLES) bits.
  - Baud counter: clog2(BAUD_DIV) bits.
  - Byte index: clog2(DIGITS+3) bits.
  - Digits: 4 bits each.

Test Plan:
1. Params GATE_CYCLES=1000, DIGITS=4, BAUD_DIV=4, EDGE_MODE=0. FREQIN square wave, period 10 clocks -> second and later frames decode as "0100=\r\n"; each bit is 4 clocks; LED1 toggles every 1000 clocks.
2. Same stimulus with LZ_BLANK=1 -> " 100=\r\n". With FREQIN held constant -> "   0=\r\n".
3. EDGE_MODE=2, period 10 -> "0200=\r\n". EDGE_MODE=1, period 10 -> "0100=\r\n".
4. DIGITS=2, period 4 (250 edges per window) -> "99>\r\n" and OVF=1. Then FREQIN stopped -> next frame "00=\r\n" and OVF=0.
5. BAUD_DIV=200 so one frame (70 bits x 200 = 14000 clocks) spans more than 2 gates -> DROP pulses once per overwrite; frames stay byte-aligned with no corruption; the frame sent is the latest snapshot.
6. Assert RST for 1 cycle in the middle of a data bit -> TXD=1 and BUSY=0 from the next cycle; the counter restarts from 0; the first post-reset frame appears after a full gate window.
